prog_mem: RTL and testbench
===========================

// Module: prog_mem
// PURPOSE
//  16-word x 8-bit program/data memory: the responder side of the toy CPU memory bus.
//  Answers CPU fetches and indirect reads combinationally, and commits CPU STA writes.
//  Provides a serial host load port so a program can be written in before or while
//  the CPU runs. Sits between the CPU core and the top-level IO pins.
// PARAMETERS
//  AW        4      address width; depth = 2**AW words
//  DW        8      data width (instruction nibble [7:4], operand nibble [3:0])
//  INIT      8'h00  reset value of every word (8'h00 = NOP)
// PORTS
//  clk        in   1    system clock; all state updates on its FALLING edge
//  rst        in   1    asynchronous, active-high reset
//  addr       in   AW   CPU address: PC while clk low, operand address while clk high
//  we         in   1    CPU write enable (STA)
//  data_out   in   DW   CPU write data (CPU's data_out, {4'b0, accu})
//  data_in    out  DW   read data to CPU = mem[addr], combinational
//  load_en    in   1    host load frame enable, level; low aborts a frame in progress
//  load_sdi   in   1    host serial data, MSB first
//  load_busy  out  1    high while a frame is being shifted or written
//  load_ack   out  1    one-cycle pulse: the frame's word has been committed
// BEHAVIOUR
//  - All sequential elements update on negedge clk, so CPU writes are taken while
//    addr still carries the operand address (clk high phase).
//  - Reset (async): every word <= INIT, FSM <= IDLE, bit count <= 0, shift reg <= 0,
//    load_busy = 0, load_ack = 0; data_in therefore reads INIT.
//  - Read: data_in = mem[addr], purely combinational, no latency. A word written at
//    an edge is visible on data_in immediately after that edge.
//  - CPU write: at negedge with we=1 and no loader conflict, mem[addr] <= data_out.
//  - Load frame = 12 bits: 4-bit address (MSB first), then 8-bit data (MSB first).
//  - FSM:
//    IDLE:  load_en=1 -> shift in load_sdi as bit 11, cnt=1, go SHIFT; else stay.
//    SHIFT: load_en=1 -> shift load_sdi, cnt++; after the 12th bit is taken go WRITE.
//           load_en=0 -> abort: discard bits, cnt=0, go IDLE, memory untouched.
//    WRITE: mem[frame_addr] <= frame_data, load_ack=1 this cycle, go IDLE;
//           load_sdi ignored, load_en ignored (no abort possible in WRITE).
//  - Frame cadence: 12 shift edges + 1 WRITE edge; with load_en held high, the next
//    frame's first bit is taken on the edge after WRITE (back-to-back = 13 cycles/word).
//  - load_busy = (state != IDLE); registered, changes on negedge only.
//  - load_ack is high only for the single cycle following the WRITE edge.
//  - Collision: loader WRITE and CPU we=1 on the same edge:
//    same address -> loader data wins, CPU write dropped;
//    different addresses -> both commit.
//  - Reset mid-frame: frame discarded, no ack, memory returned to INIT.
//  - No address wrap issues: AW-bit address covers the whole array; all 16 words
//    are writable.
// TESTING
//  1. Assert rst, release -> data_in=8'h00 for addr 0..15; load_busy=0, load_ack=0.
//  2. load_en=1, shift 12'b0011_0001_0101 -> load_busy during frame; load_ack pulses
//     one cycle after the WRITE edge; addr=3 reads 8'h15.
//  3. we=1, addr=5, data_out=8'h0A at a falling edge -> addr=5 reads 8'h0A right
//     after the edge; all other words unchanged.
//  4. Loader WRITE {5, 8'h77} on the same edge as CPU we addr=5, data 8'h0A ->
//     addr 5 = 8'h77. Repeat with CPU addr=6 -> addr 5 = 8'h77 and addr 6 = 8'h0A.
//  5. Drop load_en after 6 bits -> no load_ack; load_busy=0 next cycle; memory
//     unchanged; a full new frame then loads correctly.
//  6. Assert rst during bit 8 of a frame after loading addr 2 = 8'hA5 -> load_busy=0,
//     no ack, addr 2 reads 8'h00; two back-to-back frames (load_en held high) both
//     commit, with acks 13 cycles apart.

Source files
------------

// File: rtl/prog_mem.sv
// prog_mem: 16x8 program/data memory answering CPU reads combinationally, taking CPU STA writes
// and serial host-loaded words. Read latency 0; CPU write and loader commit on the falling clk edge.
// No backpressure: the host frames with load_en and gets load_busy/load_ack; a loader commit wins an address collision.
module prog_mem #(
    parameter int                AW   = 4,
    parameter int                DW   = 8,
    parameter logic [DW-1:0]     INIT = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] data_out,
    output logic [DW-1:0] data_in,
    input  logic          load_en,
    input  logic          load_sdi,
    output logic          load_busy,
    output logic          load_ack
);

    localparam int DEPTH = 2 ** AW;
    // One frame is an address followed by a data word, both MSB first.
    localparam int FW = AW + DW;
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } ld_state_t;

    ld_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     sr_q, sr_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     mem_d [DEPTH];

    logic [AW-1:0]     frame_addr;
    logic [DW-1:0]     frame_data;
    logic              ld_wr;
    logic              cpu_wr;

    // After the last shift the register holds {address, data} in frame order.
    assign frame_addr = sr_q[FW-1 -: AW];
    assign frame_data = sr_q[DW-1:0];

    // The loader commits from the WRITE state; a CPU write to the same word that edge is dropped.
    assign ld_wr  = (state_q == WRITE);
    assign cpu_wr = we && !(ld_wr && (frame_addr == addr));

    // Loader FSM: collect FW serial bits, abort on load_en low, then one commit cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_en) begin
                    sr_d    = {{(FW-1){1'b0}}, load_sdi};
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (load_en) begin
                    sr_d = {sr_q[FW-2:0], load_sdi};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // Aborted frame: forget the partial bits, memory is left alone.
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                // load_en and load_sdi are ignored here; the commit cannot be aborted.
                ack_d   = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                sr_d    = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Next memory image: CPU write first, then the loader so it overrides on a shared address.
    always_comb begin
        mem_d = mem_q;
        if (cpu_wr) begin
            mem_d[addr] = data_out;
        end
        if (ld_wr) begin
            mem_d[frame_addr] = frame_data;
        end
    end

    // Loader state and status flags, updated on the falling edge while addr holds the operand.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    // Storage array, returned to INIT by reset.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign data_in   = mem_q[addr];
    assign load_busy = busy_q;
    assign load_ack  = ack_q;

endmodule

// File: tb/tb_prog_mem.sv
`timescale 1ns/1ps
module tb_prog_mem;

    logic       clk;
    logic       rst;
    logic [3:0] addr;
    logic       we;
    logic [7:0] data_out;
    logic [7:0] data_in;
    logic       load_en;
    logic       load_sdi;
    logic       load_busy;
    logic       load_ack;

    prog_mem #(.AW(4), .DW(8), .INIT(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .we        (we),
        .data_out  (data_out),
        .data_in   (data_in),
        .load_en   (load_en),
        .load_sdi  (load_sdi),
        .load_busy (load_busy),
        .load_ack  (load_ack)
    );

    initial begin
        clk = 1'b1;
        forever #20 clk = ~clk;
    end

    int passes = 0;
    int checks = 0;

    // Reference model: memory contents plus a count of frame bits collected so far.
    logic [7:0]  ref_mem [16];
    logic [11:0] m_frame;
    int          m_bits;
    bit          m_pend;
    int          cyc;
    int          ack_cyc [$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%02h expected=%02h at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        m_frame = '0;
        m_bits  = 0;
        m_pend  = 1'b0;
    endtask

    // One falling edge with the given inputs; update the model and check the outputs afterwards.
    task automatic step(input bit le, input bit sdi, input bit w, input logic [3:0] a,
                        input logic [7:0] d);
        bit         commit;
        logic [3:0] fa;
        logic [7:0] fd;
        load_en  = le;
        load_sdi = sdi;
        we       = w;
        addr     = a;
        data_out = d;
        @(negedge clk);
        commit = m_pend;
        fa     = m_frame[11:8];
        fd     = m_frame[7:0];
        if (m_pend) begin
            m_pend = 1'b0;
            m_bits = 0;
        end else if (le) begin
            m_frame = {m_frame[10:0], sdi};
            m_bits++;
            if (m_bits == 12) begin
                m_pend = 1'b1;
                m_bits = 0;
            end
        end else begin
            m_bits = 0;
        end
        if (w && !(commit && fa == a)) ref_mem[a] = d;
        if (commit) ref_mem[fa] = fd;
        cyc++;
        #1;
        chk("busy", {7'b0, load_busy}, {7'b0, (m_pend || m_bits != 0)});
        chk("ack",  {7'b0, load_ack},  {7'b0, commit});
        chk("rd",   data_in, ref_mem[a]);
        if (load_ack) ack_cyc.push_back(cyc);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            chk(tag, data_in, ref_mem[i]);
        end
    endtask

    // Shift a full frame, then the commit cycle carrying an optional CPU write.
    task automatic send_frame(input logic [3:0] fa, input logic [7:0] fd, input bit le_wr,
                              input bit w, input logic [3:0] ca, input logic [7:0] cd);
        logic [11:0] f;
        f = {fa, fd};
        for (int i = 11; i >= 0; i--) step(1'b1, f[i], 1'b0, fa, 8'h00);
        step(le_wr, 1'b0, w, ca, cd);
    endtask

    initial begin
        rst = 1'b1; addr = '0; we = 0; data_out = '0; load_en = 0; load_sdi = 0;
        cyc = 0;
        model_reset();
        #50;
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_busy", {7'b0, load_busy}, 8'h00);
        chk("rst_ack",  {7'b0, load_ack},  8'h00);
        sweep("rst_rd");

        // Basic serial load of 0x15 into word 3
        send_frame(4'd3, 8'h15, 1'b0, 1'b0, 4'd3, 8'h00);
        addr = 4'd3; #1;
        chk("load3", data_in, 8'h15);

        // CPU write visible immediately after the edge
        step(1'b0, 1'b0, 1'b1, 4'd5, 8'h0A);
        chk("cpu5", data_in, 8'h0A);
        step(1'b0, 1'b0, 1'b0, 4'd5, 8'h00);
        sweep("cpu_sweep");

        // Collision on the same address: loader wins
        send_frame(4'd5, 8'h77, 1'b0, 1'b1, 4'd5, 8'h0A);
        chk("coll_same", data_in, 8'h77);
        // Collision on different addresses: both land
        send_frame(4'd5, 8'h77, 1'b0, 1'b1, 4'd6, 8'h0A);
        addr = 4'd5; #1; chk("coll_a5", data_in, 8'h77);
        addr = 4'd6; #1; chk("coll_a6", data_in, 8'h0A);

        // Abort after 6 bits, then a good frame
        ack_cyc.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 1'(i & 1), 1'b0, 4'd9, 8'h00);
        step(1'b0, 1'b0, 1'b0, 4'd9, 8'h00);
        chk("abort_busy", {7'b0, load_busy}, 8'h00);
        step(1'b0, 1'b0, 1'b0, 4'd9, 8'h00);
        chk("abort_noack", 8'(ack_cyc.size()), 8'd0);
        sweep("abort_sweep");
        send_frame(4'd9, 8'hC3, 1'b0, 1'b0, 4'd9, 8'h00);
        chk("after_abort", data_in, 8'hC3);

        // Reset in the middle of a frame
        send_frame(4'd2, 8'hA5, 1'b0, 1'b0, 4'd2, 8'h00);
        chk("load2", data_in, 8'hA5);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
        #5 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {7'b0, load_busy}, 8'h00);
        chk("mid_rst_ack",  {7'b0, load_ack},  8'h00);
        chk("mid_rst_rd2",  data_in, 8'h00);
        #1 rst = 1'b0;
        load_en = 1'b0;
        model_reset();

        // Back-to-back frames with load_en held through the commit cycle
        ack_cyc.delete();
        send_frame(4'd14, 8'h3C, 1'b1, 1'b0, 4'd14, 8'h00);
        send_frame(4'd15, 8'hE1, 1'b0, 1'b0, 4'd15, 8'h00);
        chk("b2b_acks", 8'(ack_cyc.size()), 8'd2);
        if (ack_cyc.size() == 2) chk("b2b_gap", 8'(ack_cyc[1] - ack_cyc[0]), 8'd13);
        sweep("b2b_sweep");

        // Randomized frames, aborts and CPU writes against the model
        for (int n = 0; n < 40; n++) begin
            logic [11:0] f;
            int          nb;
            f  = 12'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 12;
            for (int i = 0; i < nb; i++)
                step(1'b1, f[11 - i], 1'($urandom), 4'($urandom), 8'($urandom));
            if (nb == 12) begin
                step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 1) ? f[11:8] : 4'($urandom), 8'($urandom));
            end else begin
                step(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
            end
            if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 1'($urandom), 4'($urandom), 8'($urandom));
        end
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        sweep("rand_sweep");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
